// File: rtl/fei4_deser_pkg.sv
// fei4_deser shared types and constants.
// K28.5 comma codes and the alignment FSM state encoding.
package fei4_deser_pkg;

  localparam int WORD_W = 10;

  localparam logic [WORD_W-1:0] K28_5_RDN = 10'h0FA;
  localparam logic [WORD_W-1:0] K28_5_RDP = 10'h305;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter.
// One instance per triplicated register group.
module tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] y_o
);

  assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/fei4_deser.sv
// 8b10b serial deserializer with K28.5 comma alignment.
// FSM state and counters are triplicated and majority voted.
module fei4_deser
  import fei4_deser_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              is_comma,
  output logic              locked,
  output logic              realign
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

  logic [WORD_W-1:0] sh_q;
  state_t            st_q0, st_q1, st_q2;
  logic [3:0]        bit_q0, bit_q1, bit_q2;
  logic [3:0]        good_q0, good_q1, good_q2;
  logic [3:0]        bad_q0, bad_q1, bad_q2;

  logic [1:0] st_raw;
  state_t     st_v, st_d;
  logic [3:0] bit_v, bit_d;
  logic [3:0] good_v, good_d;
  logic [3:0] bad_v, bad_d;

  logic hit, bnd, cap, rea;

  logic [WORD_W-1:0] dout_q;
  logic              valid_q, comma_q, locked_q, rea_q;

  tmr_vote #(.W(2)) u_vote_st (
    .a_i(st_q0), .b_i(st_q1), .c_i(st_q2), .y_o(st_raw)
  );
  tmr_vote #(.W(4)) u_vote_bit (
    .a_i(bit_q0), .b_i(bit_q1), .c_i(bit_q2), .y_o(bit_v)
  );
  tmr_vote #(.W(4)) u_vote_good (
    .a_i(good_q0), .b_i(good_q1), .c_i(good_q2), .y_o(good_v)
  );
  tmr_vote #(.W(4)) u_vote_bad (
    .a_i(bad_q0), .b_i(bad_q1), .c_i(bad_q2), .y_o(bad_v)
  );

  assign st_v = state_t'(st_raw);
  assign hit  = (sh_q == K28_5_RDN) || (sh_q == K28_5_RDP);
  assign bnd  = (bit_v == 4'd9);

  // All copies take the same voted next value, scrubbing any upset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      st_q0   <= HUNT;
      st_q1   <= HUNT;
      st_q2   <= HUNT;
      bit_q0  <= '0;
      bit_q1  <= '0;
      bit_q2  <= '0;
      good_q0 <= '0;
      good_q1 <= '0;
      good_q2 <= '0;
      bad_q0  <= '0;
      bad_q1  <= '0;
      bad_q2  <= '0;
    end else begin
      sh_q    <= {sh_q[WORD_W-2:0], din};
      st_q0   <= st_d;
      st_q1   <= st_d;
      st_q2   <= st_d;
      bit_q0  <= bit_d;
      bit_q1  <= bit_d;
      bit_q2  <= bit_d;
      good_q0 <= good_d;
      good_q1 <= good_d;
      good_q2 <= good_d;
      bad_q0  <= bad_d;
      bad_q1  <= bad_d;
      bad_q2  <= bad_d;
    end
  end

  always_comb begin
    st_d   = st_v;
    bit_d  = bnd ? 4'd0 : bit_v + 4'd1;
    good_d = good_v;
    bad_d  = bad_v;
    unique case (st_v)
      HUNT: begin
        if (hit) begin
          bit_d  = 4'd0;
          good_d = 4'd1;
          st_d   = (LOCK_C == 4'd1) ? LOCKED : LOCKING;
        end
      end
      LOCKING: begin
        if (bnd) begin
          if (hit) begin
            good_d = sat_inc(good_v);
            if (good_d == LOCK_C) st_d = LOCKED;
          end
        end else if (hit) begin
          bit_d  = 4'd0;
          good_d = 4'd1;
        end
      end
      LOCKED: begin
        if (bnd) begin
          if (hit) bad_d = 4'd0;
        end else if (hit) begin
          bad_d = sat_inc(bad_v);
          if (bad_d == UNLOCK_C) begin
            st_d   = HUNT;
            good_d = 4'd0;
            bad_d  = 4'd0;
          end
        end
      end
      default: begin
        st_d   = HUNT;
        good_d = 4'd0;
        bad_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    cap = 1'b0;
    rea = 1'b0;
    unique case (st_v)
      HUNT: begin
        cap = hit;
        rea = hit;
      end
      LOCKING: begin
        cap = bnd || hit;
        rea = !bnd && hit;
      end
      LOCKED:  cap = bnd;
      default: cap = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q   <= '0;
      valid_q  <= 1'b0;
      comma_q  <= 1'b0;
      locked_q <= 1'b0;
      rea_q    <= 1'b0;
    end else begin
      if (cap) begin
        dout_q  <= sh_q;
        comma_q <= hit;
      end
      valid_q  <= cap;
      rea_q    <= rea;
      locked_q <= (st_d == LOCKED);
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign is_comma   = comma_q;
  assign locked     = locked_q;
  assign realign    = rea_q;

endmodule
